// File: rtl/dsp_xor_pkg.sv
// Shared constants, state type and LFSR step function for the streaming XOR decoder.
package dsp_xor_pkg;

   localparam logic [3:0] ALUMODE_XOR     = 4'b0100;
   localparam logic [8:0] OPMODE_XOR_AB_C = 9'b000110011;
   localparam logic [4:0] INMODE_NONE     = 5'b00000;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Fibonacci step: shift left, feedback is parity of the tapped bits.
   function automatic logic [47:0] lfsr_step(input logic [47:0] state, input logic [47:0] taps);
      return {state[46:0], ^(state & taps)};
   endfunction

endpackage

// File: rtl/dsp_xor_dec_lfsr.sv
// 48-bit keystream LFSR: seed load (zero seed forced to 1), single step per enable.
module dsp_xor_dec_lfsr
   import dsp_xor_pkg::*;
#(
   parameter logic [47:0] TAPS = 48'hC000_0018_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic [47:0] seed,
   input  logic        step,
   output logic [47:0] state
);

   // A seed load wins over a coincident step.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= 48'h1;
      end else if (load) begin
         state <= (seed == '0) ? 48'h1 : seed;
      end else if (step) begin
         state <= lfsr_step(state, TAPS);
      end
   end

endmodule

// File: rtl/dsp_xor_dec.sv
// Streaming XOR decoder top: FSM, handshake, word counter and XOR/output stage.
// Define DSP_XOR_DEC_PRIM_EN to place the XOR and output register in a DSP48E2.
module dsp_xor_dec
   import dsp_xor_pkg::*;
#(
   parameter int unsigned WIDTH = 48,
   parameter logic [47:0] TAPS  = 48'hC000_0018_0000,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             seed_valid,
   input  logic [47:0]      seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] count
);

   if ((WIDTH < 1) || (WIDTH > 48)) begin : g_width_check
      $error("dsp_xor_dec: WIDTH must be within 1..48");
   end

   state_t      state;
   logic [47:0] key;
   logic        accept;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   dsp_xor_dec_lfsr #(
      .TAPS(TAPS)
   ) u_lfsr (
      .clock  (clock),
      .reset_n(reset_n),
      .load   (seed_valid),
      .seed   (seed),
      .step   (accept),
      .state  (key)
   );

   // A seed load keeps the decoder running even when it lands on the last word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else if (seed_valid) begin
         state <= RUN;
      end else if (accept && in_last) begin
         state <= IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (seed_valid) begin
         count <= '0;
      end else if (accept) begin
         count <= count + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DSP_XOR_DEC_PRIM_EN
   logic [1:0]  rst_sync;
   logic        rstp;
   logic [47:0] ab;
   logic [47:0] p;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rstp     = !rst_sync[1];
   assign ab       = 48'(in_data);
   assign out_data = p[WIDTH-1:0];

   // P = (A:B) XOR C, registered in PREG and enabled only on accept.
   DSP48E2 #(
      .AREG         (0),
      .BREG         (0),
      .CREG         (0),
      .MREG         (0),
      .PREG         (1),
      .ACASCREG     (0),
      .BCASCREG     (0),
      .ADREG        (0),
      .DREG         (0),
      .ALUMODEREG   (0),
      .OPMODEREG    (0),
      .INMODEREG    (0),
      .CARRYINREG   (0),
      .CARRYINSELREG(0),
      .USE_MULT     ("NONE"),
      .A_INPUT      ("DIRECT"),
      .B_INPUT      ("DIRECT")
   ) u_dsp (
      .CLK          (clock),
      .A            (ab[47:18]),
      .B            (ab[17:0]),
      .C            (key),
      .D            (27'd0),
      .ALUMODE      (ALUMODE_XOR),
      .OPMODE       (OPMODE_XOR_AB_C),
      .INMODE       (INMODE_NONE),
      .CARRYIN      (1'b0),
      .CARRYINSEL   (3'b000),
      .CEA1         (1'b0),
      .CEA2         (1'b0),
      .CEB1         (1'b0),
      .CEB2         (1'b0),
      .CEC          (1'b0),
      .CED          (1'b0),
      .CEAD         (1'b0),
      .CEM          (1'b0),
      .CEP          (accept),
      .CEALUMODE    (1'b0),
      .CECTRL       (1'b0),
      .CEINMODE     (1'b0),
      .CECARRYIN    (1'b0),
      .RSTA         (1'b0),
      .RSTB         (1'b0),
      .RSTC         (1'b0),
      .RSTD         (1'b0),
      .RSTM         (1'b0),
      .RSTP         (rstp),
      .RSTALUMODE   (1'b0),
      .RSTCTRL      (1'b0),
      .RSTINMODE    (1'b0),
      .RSTALLCARRYIN(1'b0),
      .P            (p)
   );
`else
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data <= '0;
      end else if (accept) begin
         out_data <= in_data ^ key[WIDTH-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_dsp_xor_dec.sv
// Self-checking bench for dsp_xor_dec: directed scenarios plus a scoreboard of decoded words.
module tb_dsp_xor_dec;

   localparam int unsigned WIDTH = 48;
   localparam int unsigned CNT_W = 32;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             seed_valid = 1'b0;
   logic [47:0]      seed = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic [CNT_W-1:0] count;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;
   exp_t sb[$];

   logic             m_run;
   logic             m_ov;
   logic [47:0]      m_lfsr;
   logic [CNT_W-1:0] m_count;
   logic             exp_ready;
   logic             m_acc;

   dsp_xor_dec #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .seed_valid(seed_valid),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .count     (count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Taps at bits 47, 46, 20, 19.
   function automatic logic [47:0] m_step(input logic [47:0] s);
      return {s[46:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
   endfunction

   // Inputs only change just after a rising edge, so at the falling edge they
   // describe exactly what the coming rising edge will see.
   always @(negedge clock) begin
      if (!reset_n) begin
         sb.delete();
         m_run   = 1'b0;
         m_ov    = 1'b0;
         m_lfsr  = 48'h1;
         m_count = '0;
      end else begin
         exp_ready = m_run && (!m_ov || out_ready);
         check("in_ready", 64'(in_ready), 64'(exp_ready));
         check("out_valid", 64'(out_valid), 64'(m_ov));
         check("count", 64'(count), 64'(m_count));
         if (m_ov) begin
            if (sb.size() == 0) begin
               check("sb_size", 64'(sb.size()), 64'd1);
            end else begin
               check("out_data", 64'(out_data), 64'(sb[0].data));
               check("out_last", 64'(out_last), 64'(sb[0].last));
               if (out_ready) void'(sb.pop_front());
            end
         end
         m_acc = in_valid && exp_ready;
         if (m_acc) sb.push_back({in_data ^ m_lfsr[WIDTH-1:0], in_last});
         if (m_acc) m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
         if (seed_valid) begin
            m_lfsr  = (seed == 48'h0) ? 48'h1 : seed;
            m_count = '0;
            m_run   = 1'b1;
         end else if (m_acc) begin
            m_lfsr  = m_step(m_lfsr);
            m_count = m_count + 1;
            if (in_last) m_run = 1'b0;
         end
      end
   end

   task automatic cyc(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      int unsigned sent;

      cyc(2);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b1;
      cyc(1);

      // Seed 1, three zero words: keys 1, 2, 4.
      out_ready = 1'b1; seed = 48'h1; seed_valid = 1'b1;
      cyc(1);
      seed_valid = 1'b0; in_valid = 1'b1; in_data = '0; in_last = 1'b0;
      cyc(1);
      check("t1_w0", 64'(out_data), 64'h1);
      check("t1_l0", 64'(out_last), 64'd0);
      cyc(1);
      check("t1_w1", 64'(out_data), 64'h2);
      in_last = 1'b1;
      cyc(1);
      check("t1_w2", 64'(out_data), 64'h4);
      check("t1_l2", 64'(out_last), 64'd1);
      check("t1_count", 64'(count), 64'd3);
      check("t1_idle", 64'(in_ready), 64'd0);
      in_last = 1'b0;

      // Idle with in_valid held and no seed.
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("t2_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      cyc(1);

      // Stall: output must hold under backpressure.
      out_ready = 1'b0; seed = 48'hA5; seed_valid = 1'b1;
      cyc(1);
      seed_valid = 1'b0; in_valid = 1'b1; in_data = 48'hFF; in_last = 1'b1;
      cyc(1);
      in_valid = 1'b0; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold", 64'(out_data), 64'h5A);
         check("t3_valid", 64'(out_valid), 64'd1);
         check("t3_ready", 64'(in_ready), 64'd0);
         cyc(1);
      end
      out_ready = 1'b1;
      cyc(1);
      check("t3_drain", 64'(out_valid), 64'd0);

      // Zero seed maps to key 1.
      seed = '0; seed_valid = 1'b1;
      cyc(1);
      seed_valid = 1'b0; in_valid = 1'b1; in_data = 48'h7; in_last = 1'b1;
      cyc(1);
      check("t4_zero_seed", 64'(out_data), 64'h6);
      in_valid = 1'b0; in_last = 1'b0;
      cyc(1);

      // Seed load coincident with an accepted last word.
      seed = 48'h1; seed_valid = 1'b1;
      cyc(1);
      in_valid = 1'b1; in_data = '0; in_last = 1'b1; seed = 48'h10; seed_valid = 1'b1;
      cyc(1);
      check("t5_old_key", 64'(out_data), 64'h1);
      check("t5_count", 64'(count), 64'd0);
      check("t5_still_run", 64'(in_ready), 64'd1);
      seed_valid = 1'b0;
      cyc(1);
      check("t5_new_key", 64'(out_data), 64'h10);
      check("t5_count2", 64'(count), 64'd1);
      in_valid = 1'b0; in_last = 1'b0;
      cyc(1);

      // Random frame with random backpressure and gaps.
      seed = {$urandom, $urandom}; seed = seed & 48'hFFFF_FFFF_FFFF; seed_valid = 1'b1;
      cyc(1);
      seed_valid = 1'b0;
      sent = 0;
      for (int i = 0; i < 400 && sent < 20; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
         in_last   = (sent == 19);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc = in_valid && in_ready;
         cyc(1);
         if (acc) sent++;
      end
      check("t6_sent", 64'(sent), 64'd20);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      cyc(3);
      check("t6_count", 64'(count), 64'd20);

      // Reset mid-frame drops the pending word.
      seed = 48'h3; seed_valid = 1'b1;
      cyc(1);
      seed_valid = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h55;
      cyc(1);
      in_valid = 1'b0;
      check("t7_pending", 64'(out_valid), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("t7_out_valid", 64'(out_valid), 64'd0);
      check("t7_out_data", 64'(out_data), 64'd0);
      check("t7_count", 64'(count), 64'd0);
      check("t7_in_ready", 64'(in_ready), 64'd0);
      cyc(2);
      reset_n = 1'b1;
      out_ready = 1'b1;
      cyc(2);
      check("t7_idle", 64'(in_ready), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
